// File: rtl/eth_rx_frame_fifo_if.sv
// AXI-Stream beat bundle used on both sides of the Ethernet RX frame FIFO.
// The master drives data and qualifiers, and the slave drives tready.
// tuser carries the MAC frame-error flag. It is meaningful only on tlast.
interface eth_rx_frame_fifo_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata, tkeep, tlast, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// Ethernet RX frame FIFO. It stores-and-forwards MAC RX beats and exposes only
// whole, error-free frames to the DMA consumer.
//
// Write side: frames are written speculatively at wr_ptr. They become visible
// to the reader only when a good tlast moves commit_ptr forward. A frame that is
// errored (tuser on tlast) or that hits a full buffer is discarded by rewinding
// wr_ptr to commit_ptr. The MAC cannot be stalled, so a frame that overflows
// falls into DROP and is swallowed up to its tlast.
//
// Read side: a synchronous RAM read feeds a one-word holding register
// (ram_q). That register feeds the AXIS output register. With this
// two-stage arrangement the output runs at one beat per cycle and still
// honours back-pressure.
//
// Optional build macro ETH_RX_FIFO_STATS_EN adds three 32-bit frame counters.
// Without the macro, stat_frames, stat_drop_err and stat_drop_ovf are tied to 0.
module eth_rx_frame_fifo #(
  parameter int ADDR_BITS = 9
) (
  input  logic                   clock,
  input  logic                   resetn,
  eth_rx_frame_fifo_if.slave     s_axis,
  eth_rx_frame_fifo_if.master    m_axis,
  output logic                   rx_frame_ok,
  output logic                   rx_frame_drop,
  output logic [31:0]            stat_frames,
  output logic [31:0]            stat_drop_err,
  output logic [31:0]            stat_drop_ovf
);

  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int WORD_W = 73;   // {tlast, tkeep[7:0], tdata[63:0]}

  typedef logic [ADDR_BITS-1:0] ptr_t;
  typedef logic [WORD_W-1:0]    word_t;

  typedef enum logic {
    RECV = 1'b0,
    DROP = 1'b1
  } wr_state_e;

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  word_t     mem [DEPTH];
  word_t     ram_q;           // word most recently read from RAM
  logic      ram_q_valid;

  wr_state_e state_q, state_d;
  ptr_t      wr_ptr_q, wr_ptr_d;
  ptr_t      commit_ptr_q, commit_ptr_d;
  ptr_t      rd_ptr_q;
  ptr_t      wr_ptr_inc;

  logic      s_ready_q;
  logic      beat_acc;
  logic      full;
  logic      mem_we;
  word_t     wr_word;

  logic      ok_d, err_d, ovf_d;

  word_t     out_word_q;
  logic      out_valid_q;
  logic      avail;
  logic      load_out;
  logic      rd_issue;

  assign s_axis.tready = s_ready_q;
  assign beat_acc      = s_axis.tvalid & s_ready_q;
  assign wr_ptr_inc    = wr_ptr_q + ptr_t'(1);
  // One slot stays unused so that "full" and "empty" can be told apart.
  assign full          = (wr_ptr_inc == rd_ptr_q);
  assign wr_word       = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};

  // ---------------------------------------------------------------------------
  // Write FSM: next-state, pointer updates and frame outcome decode
  // ---------------------------------------------------------------------------
  // Write FSM next-state and pointer/pulse decode
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    ok_d         = 1'b0;
    err_d        = 1'b0;
    ovf_d        = 1'b0;

    if (beat_acc) begin
      case (state_q)
        RECV: begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_inc;
            if (s_axis.tlast) begin
              if (!s_axis.tuser) begin
                commit_ptr_d = wr_ptr_inc;
                ok_d         = 1'b1;
              end else begin
                wr_ptr_d = commit_ptr_q;
                err_d    = 1'b1;
              end
            end
          end else begin
            // No room: discard the partial frame now. Swallow the rest unless
            // this beat already ends the frame.
            wr_ptr_d = commit_ptr_q;
            if (s_axis.tlast) begin
              ovf_d = 1'b1;
            end else begin
              state_d = DROP;
            end
          end
        end
        DROP: begin
          if (s_axis.tlast) begin
            ovf_d   = 1'b1;
            state_d = RECV;
          end
        end
        default: state_d = RECV;
      endcase
    end
  end

  // Write-side state, pointers, input ready and outcome pulses
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: state registers use non-blocking assignments so that every flop
    // samples values from before the edge, whatever the statement order.
    if (!resetn) begin
      state_q       <= RECV;
      wr_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      s_ready_q     <= 1'b0;
      rx_frame_ok   <= 1'b0;
      rx_frame_drop <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      s_ready_q     <= 1'b1;
      rx_frame_ok   <= ok_d;
      rx_frame_drop <= err_d | ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  // RAM write port and synchronous read port
  always_ff @(posedge clock) begin
    // NOTE: the RAM array and its read register have no reset. Pointers alone
    // decide which words are valid, and a reset would prevent mapping to block RAM.
    if (mem_we) begin
      mem[wr_ptr_q] <= wr_word;
    end
    if (rd_issue) begin
      ram_q <= mem[rd_ptr_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: prefetch into ram_q, then into the AXIS output register
  // ---------------------------------------------------------------------------
  // Only committed words are ever read, so a frame still being written never
  // leaks out.
  assign avail    = (rd_ptr_q != commit_ptr_q);
  assign load_out = ram_q_valid & (~out_valid_q | m_axis.tready);
  assign rd_issue = avail & (~ram_q_valid | load_out);

  // Read pointer, prefetch occupancy and output register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q    <= '0;
      ram_q_valid <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      if (rd_issue) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
      ram_q_valid <= rd_issue | (ram_q_valid & ~load_out);
      if (load_out) begin
        out_word_q  <= ram_q;
        out_valid_q <= 1'b1;
      end else if (m_axis.tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tlast  = out_word_q[72];
  assign m_axis.tkeep  = out_word_q[71:64];
  assign m_axis.tdata  = out_word_q[63:0];
  assign m_axis.tuser  = 1'b0;

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef ETH_RX_FIFO_STATS_EN
  logic [31:0] frames_q, drop_err_q, drop_ovf_q;

  // Free-running wrap-around counters, one per frame outcome
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frames_q   <= '0;
      drop_err_q <= '0;
      drop_ovf_q <= '0;
    end else begin
      if (ok_d)  frames_q   <= frames_q + 32'd1;
      if (err_d) drop_err_q <= drop_err_q + 32'd1;
      if (ovf_d) drop_ovf_q <= drop_ovf_q + 32'd1;
    end
  end

  assign stat_frames   = frames_q;
  assign stat_drop_err = drop_err_q;
  assign stat_drop_ovf = drop_ovf_q;
`else
  assign stat_frames   = '0;
  assign stat_drop_err = '0;
  assign stat_drop_ovf = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Directed testbench for eth_rx_frame_fifo (built with ADDR_BITS=4, 15 usable words).
// Good frames are pushed onto an expected-beat queue when they are sent. A
// negedge monitor pops the queue and checks every beat the consumer accepts.
// It also checks that AXIS outputs hold steady while stalled, and it counts
// the outcome pulses.
module tb_eth_rx_frame_fifo;

`ifdef ETH_RX_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_rx_frame_fifo_if s_if ();
  eth_rx_frame_fifo_if m_if ();

  logic        rx_frame_ok, rx_frame_drop;
  logic [31:0] stat_frames, stat_drop_err, stat_drop_ovf;

  eth_rx_frame_fifo #(.ADDR_BITS(4)) dut (
    .clock         (clk),
    .resetn        (rst_n),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .rx_frame_ok   (rx_frame_ok),
    .rx_frame_drop (rx_frame_drop),
    .stat_frames   (stat_frames),
    .stat_drop_err (stat_drop_err),
    .stat_drop_ovf (stat_drop_ovf)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [72:0] exp_q [$];
  int ok_cnt = 0, drop_cnt = 0;            // pulses seen by the monitor
  int exp_ok = 0, exp_drop = 0;            // pulses expected overall
  int st_frames = 0, st_err = 0, st_ovf = 0; // expected stats since last reset
  int fid = 0;
  bit done = 1'b0;

  logic [72:0] cur_word;
  assign cur_word = {m_if.tlast, m_if.tkeep, m_if.tdata};

  task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_data(input int id, input int b);
    return {16'(id), 16'(b), 32'hC0DE_0000 ^ 32'(id * 37 + b)};
  endfunction

  // One frame, back to back, one beat per cycle. tuser is raised on the first
  // non-last beat to show that it is ignored there.
  task automatic send_frame(input int n, input bit err, input logic [7:0] last_keep,
                            input bit good);
    fid++;
    for (int i = 0; i < n; i++) begin
      s_if.tdata  = beat_data(fid, i);
      s_if.tkeep  = (i == n - 1) ? last_keep : 8'hFF;
      s_if.tlast  = (i == n - 1);
      s_if.tuser  = (i == n - 1) ? err : (i == 0);
      s_if.tvalid = 1'b1;
      if (good) exp_q.push_back({s_if.tlast, s_if.tkeep, s_if.tdata});
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic send_partial(input int n);
    fid++;
    for (int i = 0; i < n; i++) begin
      s_if.tdata  = beat_data(fid, i);
      s_if.tkeep  = 8'hFF;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      s_if.tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(tag, 73'(exp_q.size()), 73'd0);
  endtask

  task automatic check_first_latency(input string tag);
    int n = 0;
    while (!m_if.tvalid && n < 6) begin
      @(posedge clk); #1; n++;
    end
    check(tag, 73'(n <= 2), 73'd1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ok_pulses"}, 73'(ok_cnt), 73'(exp_ok));
    check({tag, "_drop_pulses"}, 73'(drop_cnt), 73'(exp_drop));
    check({tag, "_stat_frames"}, 73'(stat_frames), STATS ? 73'(st_frames) : 73'd0);
    check({tag, "_stat_drop_err"}, 73'(stat_drop_err), STATS ? 73'(st_err) : 73'd0);
    check({tag, "_stat_drop_ovf"}, 73'(stat_drop_ovf), STATS ? 73'(st_ovf) : 73'd0);
  endtask

  // Output monitor: beat scoreboard, stall stability and pulse counting
  logic [72:0] prev_word;
  bit          prev_hold = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 73'(m_if.tvalid), 73'd1);
        check("hold_data", cur_word, prev_word);
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) check("spurious_beat", 73'(m_if.tvalid), 73'd0);
        else check("beat", cur_word, exp_q.pop_front());
      end
      prev_hold = m_if.tvalid && !m_if.tready;
      prev_word = cur_word;
      if (rx_frame_ok)   ok_cnt++;
      if (rx_frame_drop) drop_cnt++;
    end
  end

  initial begin
    logic [7:0] lfsr;
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    s_if.tuser = 1'b0; s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_tready", 73'(s_if.tready), 73'd0);
    check("rst_m_tvalid", 73'(m_if.tvalid), 73'd0);
    check("rst_m_word", cur_word, 73'd0);
    check("rst_pulses", 73'({rx_frame_ok, rx_frame_drop}), 73'd0);
    check_counts("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("run_s_tready", 73'(s_if.tready), 73'd1);

    // Three good frames of 1, 8 and 9 beats
    m_if.tready = 1'b1;
    send_frame(1, 1'b0, 8'h0F, 1'b1); exp_ok++; st_frames++;
    check_first_latency("lat_1beat");
    wait_drain("drain_1beat");
    send_frame(8, 1'b0, 8'h0F, 1'b1); exp_ok++; st_frames++;
    check_first_latency("lat_8beat");
    wait_drain("drain_8beat");
    send_frame(9, 1'b0, 8'h0F, 1'b1); exp_ok++; st_frames++;
    check_first_latency("lat_9beat");
    wait_drain("drain_9beat");
    check_counts("good3");

    // Errored 8-beat frame, then a good 2-beat frame
    send_frame(8, 1'b1, 8'hFF, 1'b0); exp_drop++; st_err++;
    send_frame(2, 1'b0, 8'h03, 1'b1); exp_ok++; st_frames++;
    wait_drain("drain_err");
    check_counts("err");

    // Overflow: 20-beat frame with consumer stalled, then a 15-beat frame that fits exactly
    m_if.tready = 1'b0;
    send_frame(20, 1'b0, 8'hFF, 1'b0); exp_drop++; st_ovf++;
    repeat (4) @(posedge clk);
    #1;
    check("ovf_no_tvalid", 73'(m_if.tvalid), 73'd0);
    check_counts("ovf");
    send_frame(15, 1'b0, 8'h01, 1'b1); exp_ok++; st_frames++;
    repeat (4) @(posedge clk);
    #1;
    check("full_frame_tvalid", 73'(m_if.tvalid), 73'd1);
    check("full_frame_first", cur_word, exp_q[0]);
    m_if.tready = 1'b1;
    wait_drain("drain_full15");
    check_counts("full15");

    // Random back-pressure while frames keep streaming in
    m_if.tready = 1'b0;
    send_frame(5, 1'b0, 8'h7F, 1'b1); exp_ok++; st_frames++;
    lfsr = 8'h5A;
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 12; f++) begin
          send_frame(4, 1'b0, 8'h3F, 1'b1); exp_ok++; st_frames++;
          repeat (6) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_if.tready = ~(lfsr[0] & lfsr[1]);
          lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
      end
    join
    m_if.tready = 1'b1;
    wait_drain("drain_backpressure");
    check_counts("backpressure");

    // Reset mid-frame with a committed frame still pending
    m_if.tready = 1'b0;
    send_frame(3, 1'b0, 8'hFF, 1'b0); exp_ok++;
    send_partial(2);
    rst_n = 1'b0;
    #1;
    check("midrst_m_tvalid", 73'(m_if.tvalid), 73'd0);
    check("midrst_s_tready", 73'(s_if.tready), 73'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    st_frames = 0; st_err = 0; st_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    m_if.tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("postrst_empty", 73'(m_if.tvalid), 73'd0);
    check_counts("postrst");
    send_frame(2, 1'b0, 8'h0F, 1'b1); exp_ok++; st_frames++;
    wait_drain("drain_postrst");

    // Pointer wrap: 40 back-to-back 3-beat frames
    for (int f = 0; f < 40; f++) begin
      send_frame(3, 1'b0, 8'h1F, 1'b1); exp_ok++; st_frames++;
    end
    wait_drain("drain_wrap");
    check_counts("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/eth_rx_frame_fifo.md
Name: eth_rx_frame_fifo

Overview:
- Receive-side frame buffer between the Ethernet MAC RX AXI-Stream (64-bit, tkeep, tuser) and the RISC-V-side Ethernet DMA consumer.
- Stores incoming beats in on-chip RAM and releases a frame to the consumer only after its last beat is accepted with tuser=0.
- Frames marked bad (tuser=1 on tlast) or overflowing the buffer are discarded in full; the consumer never sees partial or errored frames.
- MAC side cannot be back-pressured, so this block is the only point where frames are lost, and it counts them.

Parameters:
- ADDR_BITS, 9, log2 of RAM depth in 64-bit words. Usable capacity is 2^ADDR_BITS-1 words, with one slot reserved for full detection.

Ports:
- clock  in  1  single clock for both sides.
- resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  64  MAC RX data.
- s_axis_tkeep  in  8  MAC RX byte enables.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  frame error flag; sampled only with tlast.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  always 1 out of reset.
- m_axis_tdata  out  64  frame data to consumer.
- m_axis_tkeep  out  8  byte enables, stored unmodified.
- m_axis_tlast  out  1  last beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  consumer ready.
- rx_frame_ok  out  1  one-cycle pulse when a frame is committed.
- rx_frame_drop  out  1  one-cycle pulse when a frame is discarded.
- stat_frames  out  32  committed-frame counter (optional feature).
- stat_drop_err  out  32  frames dropped for tuser=1 (optional feature).
- stat_drop_ovf  out  32  frames dropped for overflow (optional feature).

Behaviour:
- Reset values: s_axis_tready=0 while resetn=0, then 1. m_axis_tvalid=0; m_axis_tdata/tkeep/tlast=0. Pulses 0, counters 0. Pointers wr_ptr=commit_ptr=rd_ptr=0.
- RAM word is 73 bits: {tlast, tkeep, tdata}. It is written on every accepted beat while not dropping. Pointers are ADDR_BITS wide and wrap modulo 2^ADDR_BITS.
- Full condition: wr_ptr+1 == rd_ptr.
- Write FSM has two states, RECV and DROP.
- RECV, accepted beat, not full:
  - Write to RAM at wr_ptr and increment wr_ptr.
  - If tlast and tuser=0: commit_ptr <= wr_ptr+1 and pulse rx_frame_ok.
  - If tlast and tuser=1: wr_ptr <= commit_ptr and pulse rx_frame_drop (error).
- RECV, accepted beat, full:
  - Beat is not written; wr_ptr <= commit_ptr.
  - If the beat is tlast: pulse rx_frame_drop (overflow) and stay in RECV.
  - Otherwise go to DROP.
- DROP: discard beats. On an accepted tlast, pulse rx_frame_drop (overflow) and return to RECV.
- A frame longer than 2^ADDR_BITS-1 beats is always dropped.
- Read side:
  - Data available when rd_ptr != commit_ptr.
  - One-entry output register with one-cycle RAM read prefetch. Sustains one beat per cycle while available and m_axis_tready=1.
  - Standard AXIS rules: tvalid, once high, stays high with stable data until tready. No bubbles inside a committed frame when tready is held high.
- Latency: first beat of a frame is presented on m_axis_tvalid at most 2 cycles after the clock edge that accepted its good tlast, when the output register was empty.
- Simultaneous commit and read: independent, no stall. Read only ever consumes committed words.
- Overflow is evaluated against rd_ptr in the same cycle; a read freeing a slot in that cycle is seen the next cycle.
- Reset mid-frame: all pointers clear and any partial or uncommitted data is lost. No drop pulse.

Optional Feature:
- Macro ETH_RX_FIFO_STATS_EN.
- When defined: stat_frames, stat_drop_err and stat_drop_ovf are 32-bit counters. Each increments on the corresponding pulse and wraps at 2^32. All clear on reset.
- When undefined: the three outputs are constant 0 and the counters are not built. Pulse outputs are unaffected.

Test Plan:
- Three good frames of 1, 8 and 9 beats, tkeep of last beat 8'h0F, m_axis_tready=1 -> identical beats out in order, 3 rx_frame_ok pulses, first beat within 2 cycles of each tlast, stat_frames=3.
- 8-beat frame with tuser=1 on tlast, then a good 2-beat frame -> only the 2-beat frame appears, 1 rx_frame_drop pulse, stat_drop_err=1.
- ADDR_BITS=4, m_axis_tready=0, 20-beat frame -> frame dropped, stat_drop_ovf=1, m_axis_tvalid stays 0. A following 15-beat frame is committed and read out intact once tready=1.
- Good frame committed while the consumer toggles tready pseudo-randomly and new frames stream in continuously -> no data loss, tvalid/tdata stable while stalled.
- resetn asserted for 1 cycle mid-frame with committed data pending -> m_axis_tvalid=0, pointers empty. The next good frame is delivered alone.
- Pointer wrap: ADDR_BITS=4, 40 back-to-back 3-beat good frames with tready=1 -> all 40 delivered intact, zero drops.
